// File: rtl/logic_arbiter.sv
// Two-requester arbiter sharing one 16-bit bitwise unit (AND / OR / NOT / NAND).
// Round-robin grant, three-state IDLE -> EXEC -> RESP flow, completed-op counter.

module and16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_y
);
    assign o_y = i_a & i_b;
endmodule

module or16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_y
);
    assign o_y = i_a | i_b;
endmodule

module not16 (
    input  logic [15:0] i_a,
    output logic [15:0] o_y
);
    assign o_y = ~i_a;
endmodule

module or8way (
    input  logic [7:0] i_in,
    output logic       o_y
);
    assign o_y = |i_in;
endmodule

module logic_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [15:0]      req0_a,
    input  logic [15:0]      req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [15:0]      req1_a,
    input  logic [15:0]      req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [15:0]      rsp_data,
    output logic             rsp_zero,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_ptr;
    logic        r_id;
    logic [1:0]  r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;

    logic        w_any;
    logic        w_gnt;
    logic        w_accept;
    logic        w_handshake;
    logic [15:0] w_and;
    logic [15:0] w_or;
    logic [15:0] w_nota;
    logic [15:0] w_nand;
    logic [15:0] w_result;
    logic        w_lo_any;
    logic        w_hi_any;
    logic        w_zero;

    assign w_any       = req0_valid | req1_valid;
    assign w_accept    = (r_state == IDLE) && w_any;
    assign w_handshake = (r_state == RESP) && rsp_ready;

    // Grant: a lone requester wins; on a tie the one not granted last wins
    always_comb begin
        w_gnt = 1'b0;
        if (req0_valid && req1_valid)
            w_gnt = ~r_ptr;
        else if (req1_valid)
            w_gnt = 1'b1;
    end

    // Shared bitwise unit operating only on the captured operands
    and16  u_and  (.i_a(r_a),   .i_b(r_b), .o_y(w_and));
    or16   u_or   (.i_a(r_a),   .i_b(r_b), .o_y(w_or));
    not16  u_nota (.i_a(r_a),   .o_y(w_nota));
    not16  u_nand (.i_a(w_and), .o_y(w_nand));
    or8way u_lo   (.i_in(w_result[7:0]),  .o_y(w_lo_any));
    or8way u_hi   (.i_in(w_result[15:8]), .o_y(w_hi_any));

    assign w_zero = ~(w_lo_any | w_hi_any);

    // Opcode select among the unit outputs
    always_comb begin
        w_result = w_and;
        case (r_op)
            2'b00:   w_result = w_and;
            2'b01:   w_result = w_or;
            2'b10:   w_result = w_nota;
            default: w_result = w_nand;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic: accept, one execute cycle, hold until consumer takes it
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = EXEC;
            EXEC:    w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs: readies only in IDLE for the granted requester, forced low in reset
    always_comb begin
        req0_ready = rst_n && (r_state == IDLE) && w_any && !w_gnt;
        req1_ready = rst_n && (r_state == IDLE) && w_any &&  w_gnt;
        rsp_valid  = (r_state == RESP);
    end

    // Datapath: capture on accept, register result after EXEC, count handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= 1'b1;
            r_id     <= 1'b0;
            r_op     <= 2'b00;
            r_a      <= 16'h0000;
            r_b      <= 16'h0000;
            rsp_id   <= 1'b0;
            rsp_data <= 16'h0000;
            rsp_zero <= 1'b0;
            op_count <= '0;
        end else begin
            if (w_accept) begin
                r_ptr <= w_gnt;
                r_id  <= w_gnt;
                r_op  <= w_gnt ? req1_op : req0_op;
                r_a   <= w_gnt ? req1_a  : req0_a;
                r_b   <= w_gnt ? req1_b  : req0_b;
            end
            if (r_state == EXEC) begin
                rsp_data <= w_result;
                rsp_zero <= w_zero;
                rsp_id   <= r_id;
            end
            if (w_handshake)
                op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_logic_arbiter.sv
// Self-checking bench for logic_arbiter: directed cases, reset abort, wrap of a
// 2-bit counter instance, then randomized traffic against a transaction model.

module tb_logic_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [1:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_ready;

    logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero;
    logic [15:0] rsp_data;
    logic [7:0]  op_count;

    logic        d2Req0Ready, d2Req1Ready, d2RspValid, d2RspId, d2RspZero;
    logic [15:0] d2RspData;
    logic [1:0]  d2OpCount;

    int total = 0;
    int bad   = 0;
    bit lastGrant = 1'b1;
    int expCount  = 0;

    logic_arbiter #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .op_count(op_count)
    );

    logic_arbiter #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(d2Req0Ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(d2Req1Ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(d2RspValid), .rsp_ready(rsp_ready), .rsp_id(d2RspId),
        .rsp_data(d2RspData), .rsp_zero(d2RspZero), .op_count(d2OpCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] refResult(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~a;
            default: return ~(a & b);
        endcase
    endfunction

    task automatic scramble();
        req0_valid = 1'($urandom_range(0, 1));
        req1_valid = 1'($urandom_range(0, 1));
        req0_op = 2'($urandom); req1_op = 2'($urandom);
        req0_a = 16'($urandom); req0_b = 16'($urandom);
        req1_a = 16'($urandom); req1_b = 16'($urandom);
    endtask

    task automatic checkCounts(input string tag);
        checkOutput({tag, "_count8"}, op_count, expCount % 256);
        checkOutput({tag, "_count2"}, d2OpCount, expCount % 4);
    endtask

    // One full transaction: drive in IDLE, accept, EXEC, RESP (held holdCycles), handshake.
    // Returns right after the handshake edge so the next call drives on the following negedge.
    task automatic applyStimulus(input bit v0, input bit v1,
                                 input logic [1:0] op0, input logic [15:0] a0, input logic [15:0] b0,
                                 input logic [1:0] op1, input logic [15:0] a1, input logic [15:0] b1,
                                 input int holdCycles);
        bit g;
        logic [15:0] expData;
        @(negedge clk);
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        rsp_ready = 1'($urandom_range(0, 1));
        #1;
        g = (v0 && v1) ? ~lastGrant : v1;
        expData = g ? refResult(op1, a1, b1) : refResult(op0, a0, b0);
        checkCounts("idle");
        checkOutput("idle_ready0", req0_ready, !g);
        checkOutput("idle_ready1", req1_ready, g);
        checkOutput("idle_valid", rsp_valid, 0);
        @(posedge clk);
        lastGrant = g;
        @(negedge clk);
        scramble();
        rsp_ready = 1'($urandom_range(0, 1));
        #1;
        checkOutput("exec_valid", rsp_valid, 0);
        checkOutput("exec_ready0", req0_ready, 0);
        checkOutput("exec_ready1", req1_ready, 0);
        @(negedge clk);
        scramble();
        rsp_ready = (holdCycles == 0);
        #1;
        checkOutput("resp_valid", rsp_valid, 1);
        checkOutput("resp_data", rsp_data, expData);
        checkOutput("resp_zero", rsp_zero, expData == 16'h0000);
        checkOutput("resp_id", rsp_id, g);
        checkOutput("resp_ready0", req0_ready, 0);
        checkOutput("resp_ready1", req1_ready, 0);
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            scramble();
            rsp_ready = (i == holdCycles - 1);
            #1;
            checkOutput("hold_valid", rsp_valid, 1);
            checkOutput("hold_data", rsp_data, expData);
            checkOutput("hold_zero", rsp_zero, expData == 16'h0000);
            checkOutput("hold_id", rsp_id, g);
            checkOutput("hold_ready0", req0_ready, 0);
            checkOutput("hold_ready1", req1_ready, 0);
            checkCounts("hold");
        end
        @(posedge clk);
        expCount++;
    endtask

    initial begin
        // Reset state with both requesters pushing
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = 2'b00; req1_op = 2'b00;
        req0_a = 16'hFFFF; req0_b = 16'hFFFF; req1_a = 16'hFFFF; req1_b = 16'hFFFF;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_ready0", req0_ready, 0);
        checkOutput("rst_ready1", req1_ready, 0);
        checkOutput("rst_valid", rsp_valid, 0);
        checkOutput("rst_data", rsp_data, 0);
        checkOutput("rst_zero", rsp_zero, 0);
        checkOutput("rst_id", rsp_id, 0);
        checkCounts("rst");
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;

        // Directed: AND on requester 0, NAND and NOT on requester 1
        applyStimulus(1, 0, 2'b00, 16'hF0F0, 16'hFF00, 2'b01, 16'h1234, 16'h5678, 0);
        applyStimulus(0, 1, 2'b00, 16'h0000, 16'h0000, 2'b11, 16'hFFFF, 16'hFFFF, 0);
        applyStimulus(0, 1, 2'b01, 16'hAAAA, 16'h5555, 2'b10, 16'h00FF, 16'($urandom), 0);
        applyStimulus(1, 0, 2'b01, 16'h1200, 16'h0034, 2'b00, 16'h0000, 16'h0000, 0);

        // Consumer stalls five cycles in RESP
        applyStimulus(1, 1, 2'b11, 16'h0F0F, 16'h3C3C, 2'b01, 16'h8001, 16'h0110, 5);

        // Requester 0 withdraws before the edge: no accept, pointer unchanged
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b0; rsp_ready = 1'b0;
        #1;
        checkOutput("drop_ready0", req0_ready, 1);
        #2;
        req0_valid = 1'b0;
        @(posedge clk);
        applyStimulus(1, 1, 2'b00, 16'hFFFF, 16'h00F0, 2'b01, 16'h0001, 16'h0002, 0);

        // Reset during EXEC discards the operation and restores requester-0 tie priority
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        req0_op = 2'b01; req0_a = 16'h1111; req1_op = 2'b01; req1_a = 16'h2222;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        lastGrant = 1'b1;
        expCount = 0;
        #1;
        checkOutput("rstx_ready0", req0_ready, 0);
        checkOutput("rstx_ready1", req1_ready, 0);
        checkOutput("rstx_valid", rsp_valid, 0);
        checkCounts("rstx");
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rstx_after_valid", rsp_valid, 0);
        checkCounts("rstx_after");
        @(posedge clk);

        // Both valid continuously: grants alternate 0,1,0,1 and the 2-bit counter wraps
        for (int i = 0; i < 5; i++)
            applyStimulus(1, 1, 2'($urandom), 16'($urandom), 16'($urandom),
                          2'($urandom), 16'($urandom), 16'($urandom), 0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            bit v0, v1;
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            applyStimulus(v0, v1, 2'($urandom), 16'($urandom), 16'($urandom),
                          2'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 2));
        end

        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        checkCounts("final");
        checkOutput("final_valid", rsp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logic_arbiter.md
LOGIC_ARBITER -- requirements
Module: logic_arbiter

Interface
REQ-001 Parameter: CNT_W, 8, width of completed-operation counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-006 req0_op  input  2  requester 0 opcode.
REQ-007 req0_a, req0_b  input  16 each  requester 0 operands.
REQ-008 req1_valid, req1_ready, req1_op, req1_a, req1_b  same directions and widths as requester 0, for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_id  output  1  requester index that owns the result.
REQ-012 rsp_data  output  16  result word.
REQ-013 rsp_zero  output  1  high when rsp_data is all zeros, via OR-reduction of both bytes through or8way.
REQ-014 op_count  output  CNT_W  count of completed response handshakes.

Function
REQ-015 The block SHALL share one 16-bit bitwise unit built from and16, or16 and not16 between two requesters.
REQ-016 Opcodes SHALL be: 00 a AND b; 01 a OR b; 10 NOT a, with b ignored; 11 NOT (a AND b).
REQ-017 The FSM SHALL have the states IDLE, EXEC and RESP.
REQ-018 reqN_ready SHALL be combinational: high only in IDLE, and only for the granted requester.
REQ-019 Grant SHALL be combinational: if exactly one valid, that requester; if both valid, the requester not granted last (round-robin pointer).
REQ-020 On an accept edge (IDLE and reqN_valid and reqN_ready), the block SHALL:
  - capture the opcode, both operands and the id N into internal registers;
  - update the round-robin pointer to N;
  - go to EXEC.
REQ-021 Operand or valid changes after acceptance SHALL have no effect on the in-flight operation.
REQ-022 EXEC SHALL last exactly one cycle, then go to RESP, registering rsp_data, rsp_zero and rsp_id.
REQ-023 In RESP, rsp_valid SHALL be high and rsp_data, rsp_zero and rsp_id SHALL be held stable until the handshake.
REQ-024 On the handshake edge (RESP and rsp_ready), the block SHALL return to IDLE and increment op_count.
REQ-025 op_count SHALL wrap from 2^CNT_W-1 to 0.
REQ-026 rsp_valid SHALL be low in IDLE and EXEC; rsp_ready SHALL be ignored when rsp_valid is low.
REQ-027 Latency SHALL be: rsp_valid high in the 2nd cycle after the accept edge; minimum spacing between accept edges is 3 cycles.
REQ-028 No new request SHALL be accepted in EXEC or RESP, nor on the RESP handshake edge itself; the earliest next accept is the following edge.
REQ-029 A requester dropping valid before acceptance SHALL be allowed; no acceptance occurs and the pointer is unchanged.
REQ-030 With both valid and no intervening traffic, consecutive grants SHALL alternate 0, 1, 0, 1.

Reset
REQ-031 While rst_n is low, the block SHALL immediately force:
  - state to IDLE;
  - the pointer so that requester 0 wins the first tie;
  - rsp_valid, rsp_id, rsp_data, rsp_zero and op_count to 0;
  - the internal operand and opcode registers to 0.
REQ-032 While rst_n is low, req0_ready and req1_ready SHALL be 0.
REQ-033 Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response and no count.
REQ-034 After rst_n rises, operation SHALL resume from IDLE on the first clock edge.

Verification
REQ-035 Req0 op 00, a=16'hF0F0, b=16'hFF00 -> rsp_data=16'hF000, rsp_zero=0, rsp_id=0, rsp_valid 2 cycles after accept.
REQ-036 Req1 op 11, a=16'hFFFF, b=16'hFFFF -> rsp_data=16'h0000, rsp_zero=1, rsp_id=1; op 10, a=16'h00FF -> 16'hFF00.
REQ-037 Both requesters valid continuously for 4 operations with rsp_ready=1 -> grants 0,1,0,1; accept edges exactly 3 cycles apart; op_count=4.
REQ-038 rsp_ready held low 5 cycles in RESP -> rsp_valid and data held stable; both readies low; no accept until the cycle after the handshake.
REQ-039 rst_n pulsed low during EXEC -> no rsp_valid, op_count stays 0, the next tie is granted to requester 0.
REQ-040 With CNT_W=2, run 5 operations -> op_count sequence 1,2,3,0,1.
